// File: rtl/column_accumulator.sv
// column_accumulator: sums R rows of C signed-magnitude products column-wise into C results.
// Build macro ACC_SATURATE_EN clamps overflowing columns; when undefined they wrap.
`ifndef N
`define N 16
`endif
`ifndef F
`define F 8
`endif

module column_accumulator #(
    parameter int unsigned R = 3,
    parameter int unsigned C = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [C*`N-1:0] s_row,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [C*`N-1:0] m_sum,
    output logic [C-1:0]    m_ovf
);

    localparam int unsigned NW = `N;
    localparam int unsigned AW = NW + $clog2(R) + 1;
    localparam int unsigned CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] LastRow = CW'(R - 1);

    typedef enum logic {
        StAcc,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [C*AW-1:0] acc_q, acc_d;
    logic [C*NW-1:0] sum_q, sum_d;
    logic [C-1:0]    ovf_q, ovf_d;

    logic [C*AW-1:0] acc_add;
    logic [C*NW-1:0] sum_new;
    logic [C-1:0]    ovf_new;
    logic            accept;
    logic            last_row;

    // Signed magnitude to two's complement; -0 maps to 0.
    function automatic logic [AW-1:0] sm_to_tc(input logic [NW-1:0] x);
        logic [AW-1:0] mag;
        mag = {{(AW - NW + 1){1'b0}}, x[NW-2:0]};
        return x[NW-1] ? (~mag + AW'(1)) : mag;
    endfunction

    // Returns {overflow, signed-magnitude result}; a zero magnitude always yields +0.
    function automatic logic [NW:0] tc_to_sm(input logic [AW-1:0] a);
        logic [AW-1:0] abs_v;
        logic          ovf;
        logic [NW-2:0] mag;
        abs_v = a[AW-1] ? (~a + AW'(1)) : a;
        ovf   = |abs_v[AW-1:NW-1];
`ifdef ACC_SATURATE_EN
        mag   = ovf ? {(NW - 1){1'b1}} : abs_v[NW-2:0];
`else
        mag   = abs_v[NW-2:0];
`endif
        return {ovf, a[AW-1] && (mag != '0), mag};
    endfunction

    assign s_ready  = (state_q == StAcc);
    assign m_valid  = (state_q == StDone);
    assign accept   = s_valid && s_ready;
    assign last_row = (cnt_q == LastRow);
    assign m_sum    = sum_q;
    assign m_ovf    = ovf_q;

    // Per-column add of the incoming row and conversion of that candidate total.
    always_comb begin
        acc_add = '0;
        sum_new = '0;
        ovf_new = '0;
        for (int unsigned j = 0; j < C; j++) begin
            acc_add[j*AW +: AW] = acc_q[j*AW +: AW] + sm_to_tc(s_row[j*NW +: NW]);
            {ovf_new[j], sum_new[j*NW +: NW]} = tc_to_sm(acc_add[j*AW +: AW]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StAcc: begin
                if (accept) begin
                    acc_d = acc_add;
                    if (last_row) begin
                        cnt_d   = '0;
                        sum_d   = sum_new;
                        ovf_d   = ovf_new;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            StDone: begin
                if (m_ready) begin
                    acc_d   = '0;
                    state_d = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StAcc;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_column_accumulator.sv
// Self-checking bench for column_accumulator: directed cases plus randomized vectors
// checked against an integer-arithmetic reference model.
`ifndef N
`define N 16
`endif

module tb_column_accumulator;

    localparam int unsigned R  = 3;
    localparam int unsigned C  = 4;
    localparam int unsigned NB = `N;
    localparam longint MaxMag = (longint'(1) << (NB - 1)) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_valid;
    logic            s_ready;
    logic [C*NB-1:0] s_row;
    logic            m_valid;
    logic            m_ready;
    logic [C*NB-1:0] m_sum;
    logic [C-1:0]    m_ovf;

    int checks = 0;
    int errors = 0;
    longint model_acc[C];

    always #5 clk = ~clk;

    column_accumulator #(.R(R), .C(C)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_row  (s_row),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_sum  (m_sum),
        .m_ovf  (m_ovf)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic longint sm_val(input logic [NB-1:0] x);
        longint m;
        m = longint'(x[NB-2:0]);
        return x[NB-1] ? -m : m;
    endfunction

    function automatic logic [NB-1:0] exp_sum(input longint s);
        longint a;
        longint m;
        logic [NB-2:0] mm;
        a = (s < 0) ? -s : s;
`ifdef ACC_SATURATE_EN
        m = (a > MaxMag) ? MaxMag : a;
`else
        m = a % (MaxMag + 1);
`endif
        mm = m[NB-2:0];
        return {(s < 0) && (m != 0), mm};
    endfunction

    function automatic logic exp_ovf(input longint s);
        return ((s < 0) ? -s : s) > MaxMag;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int j = 0; j < C; j++) model_acc[j] = 0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_mvalid", m_valid, 1'b0);
        end
    endtask

    task automatic push_row(input logic [C*NB-1:0] row);
        int budget;
        budget  = 50;
        s_valid = 1'b1;
        s_row   = row;
        while (!s_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("accept_timeout", s_ready, 1'b1);
        check("acc_mvalid", m_valid, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        for (int j = 0; j < C; j++) model_acc[j] += sm_val(row[j*NB +: NB]);
    endtask

    task automatic collect(input string tag, input int hold);
        logic [C*NB-1:0] held_sum;
        logic [C-1:0]    held_ovf;
        int budget;
        budget = 50;
        while (!m_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_valid"}, m_valid, 1'b1);
        check({tag, "_sready"}, s_ready, 1'b0);
        for (int j = 0; j < C; j++) begin
            check({tag, "_sum"}, m_sum[j*NB +: NB], exp_sum(model_acc[j]));
            check({tag, "_ovf"}, m_ovf[j], exp_ovf(model_acc[j]));
        end
        held_sum = m_sum;
        held_ovf = m_ovf;
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold"}, {m_valid, s_ready, m_ovf, m_sum}, {2'b10, held_ovf, held_sum});
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_release"}, {m_valid, s_ready}, 2'b01);
        clear_model();
    endtask

    function automatic logic [C*NB-1:0] rand_row();
        logic [C*NB-1:0] r;
        logic [NB-1:0]   v;
        for (int j = 0; j < C; j++) begin
            v = NB'($urandom);
            if ($urandom_range(0, 1) == 1) v = v & 16'h83FF;
            r[j*NB +: NB] = v;
        end
        return r;
    endfunction

    initial begin
        logic [C*NB-1:0] ra, rb, rc;
        logic [NB-1:0]   ovf_pos, ovf_neg;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_row   = '0;
        clear_model();
        repeat (2) @(negedge clk);
        check("reset_state", {s_ready, m_valid, m_ovf, m_sum}, {2'b10, {C{1'b0}}, {(C*NB){1'b0}}});
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sum, s_valid held constant across three rows.
        push_row(64'h0000_8100_0200_0100);
        push_row(64'h0000_8100_8200_0100);
        check("basic_pre_last", m_valid, 1'b0);
        push_row(64'h8000_8100_0080_0100);
        check("basic_latency", m_valid, 1'b1);
        check("basic_const", {m_ovf, m_sum}, {4'b0000, 64'h0000_8300_0080_0300});
        collect("basic", 0);

        // Backpressure with a row held at the source while DONE.
        ra = rand_row();
        rb = rand_row();
        rc = rand_row();
        push_row(ra);
        push_row(rb);
        push_row(rc);
        s_valid = 1'b1;
        s_row   = 64'h0100_0100_0100_0100;
        collect("bp", 5);
        check("bp_not_taken", {s_ready, m_valid}, 2'b10);
        push_row(64'h0100_0100_0100_0100);
        push_row(64'h0200_0200_0200_0200);
        push_row(64'h8100_0000_8400_0100);
        check("bp_fresh_const", m_sum, 64'h0200_0300_8100_0400);
        collect("bp_next", 0);

        // Source stalls: valid pattern 1,0,0,1,0,1.
        push_row(64'h0000_8100_0200_0100);
        idle(2);
        push_row(64'h0000_8100_8200_0100);
        idle(1);
        push_row(64'h8000_8100_0080_0100);
        check("stall_const", {m_ovf, m_sum}, {4'b0000, 64'h0000_8300_0080_0300});
        collect("stall", 1);

        // Overflow in column 0, positive then negative.
`ifdef ACC_SATURATE_EN
        ovf_pos = 16'h7FFF;
        ovf_neg = 16'hFFFF;
`else
        ovf_pos = 16'h7D00;
        ovf_neg = 16'hFD00;
`endif
        repeat (3) push_row(64'h0001_0001_0001_7F00);
        check("ovf_pos_sum", m_sum[NB-1:0], ovf_pos);
        check("ovf_pos_flag", m_ovf, 4'b0001);
        collect("ovf_pos", 0);
        repeat (3) push_row(64'h8001_8001_8001_FF00);
        check("ovf_neg_sum", m_sum[NB-1:0], ovf_neg);
        check("ovf_neg_flag", m_ovf, 4'b0001);
        collect("ovf_neg", 0);

        // Cancellation through negative zero must give +0.
        push_row(64'h8000_8000_8000_8000);
        push_row(64'h0200_0200_0200_0200);
        push_row(64'h8200_8200_8200_8200);
        check("negzero_const", {m_ovf, m_sum}, {4'b0000, 64'h0});
        collect("negzero", 0);

        // Reset mid-vector discards the partial sum.
        push_row(64'h7000_7000_7000_7000);
        push_row(64'h0300_0300_0300_0300);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_state", {s_ready, m_valid, m_ovf, m_sum}, {2'b10, {C{1'b0}}, {(C*NB){1'b0}}});
        clear_model();
        push_row(64'h0100_0100_0100_0100);
        push_row(64'h0100_0100_0100_0100);
        push_row(64'h8100_0100_0100_0100);
        check("midrst_const", m_sum, 64'h0100_0300_0300_0300);
        collect("midrst", 0);

        // Randomized vectors with random stalls and backpressure.
        for (int v = 0; v < 20; v++) begin
            for (int r = 0; r < R; r++) begin
                push_row(rand_row());
                if (r < R - 1) idle($urandom_range(0, 2));
            end
            collect("rand", $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
